// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word RAM responder with programmable busy latency; optional display mirror via MEM_RESPONDER_DISPLAY_EN
module mem_responder #(
    parameter int DEPTH        = 64,
    parameter int LATENCY      = 2,
    parameter int DISPLAY_WORD = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy
`ifdef MEM_RESPONDER_DISPLAY_EN
    ,
    output logic [31:0] display
`endif
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cnt;
    logic [3:0]         cnt_nxt;
    logic               accept;
    logic               req;

    logic               op_write;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;

    logic               entering_done;
    logic               commit_write;
    logic [IDX_W-1:0]   commit_idx;
    logic [31:0]        commit_data;

    logic [31:0]        mem [DEPTH];

    logic               unused_addr_bits;

    assign req              = ren | wen;
    assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    busy      = 1'b1;
                    accept    = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = (LATENCY > 1) ? WAIT : DONE;
                end
            end
            WAIT: begin
                busy    = 1'b1;
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // With LATENCY=1 the DONE-entering edge is the accept edge, so the
    // commit must take the live request rather than the latched copy.
    always_comb begin
        entering_done = (state != DONE) && (state_nxt == DONE);
        if (state == IDLE) begin
            commit_write = wen;
            commit_idx   = addr[IDX_W+1:2];
            commit_data  = wdata;
        end else begin
            commit_write = op_write;
            commit_idx   = idx_q;
            commit_data  = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rdata    <= 32'd0;
            op_write <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                op_write <= wen;
                idx_q    <= addr[IDX_W+1:2];
                wdata_q  <= wdata;
            end
            if (entering_done && !commit_write) begin
                rdata <= mem[commit_idx];
            end
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && entering_done && commit_write) begin
            mem[commit_idx] <= commit_data;
        end
    end

`ifdef MEM_RESPONDER_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            display <= 32'd0;
        end else if (entering_done && commit_write &&
                     commit_idx == IDX_W'(DISPLAY_WORD)) begin
            display <= commit_data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed table-driven bench for mem_responder (LATENCY=2 and LATENCY=1 instances)
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren, wen;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        busy;
    logic        ren1, wen1;
    logic [31:0] addr1, wdata1;
    logic [31:0] rdata1;
    logic        busy1;
`ifdef MEM_RESPONDER_DISPLAY_EN
    logic [31:0] display;
    logic [31:0] display1;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(64), .LATENCY(2), .DISPLAY_WORD(63)) dut (
        .clk(clk), .rst(rst), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy)
`ifdef MEM_RESPONDER_DISPLAY_EN
        , .display(display)
`endif
    );

    mem_responder #(.DEPTH(64), .LATENCY(1), .DISPLAY_WORD(63)) dut1 (
        .clk(clk), .rst(rst), .ren(ren1), .wen(wen1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .busy(busy1)
`ifdef MEM_RESPONDER_DISPLAY_EN
        , .display(display1)
`endif
    );

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        string       name;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // One LATENCY=2 transaction: busy in T and T+1, low in DONE with rdata checked.
    task automatic txn(input vec_t v);
        @(posedge clk); #1;
        ren = v.ren; wen = v.wen; addr = v.addr; wdata = v.wdata;
        @(negedge clk);
        check({v.name, " busy T"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check({v.name, " busy T+1"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check({v.name, " busy DONE"}, {31'd0, busy}, 32'd0);
        check({v.name, " rdata"}, rdata, v.exp_rdata);
        ren = 1'b0; wen = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        "wr10"};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, "rd10"};
        vecs[2]  = '{1'b0, 1'b1, 32'h8,   32'h77,       32'hDEADBEEF, "wr8"};
        vecs[3]  = '{1'b1, 1'b0, 32'h8,   32'h0,        32'h77,       "rd8"};
        vecs[4]  = '{1'b1, 1'b1, 32'h8,   32'h1234,     32'h77,       "rdwr8"};
        vecs[5]  = '{1'b1, 1'b0, 32'h8,   32'h0,        32'h1234,     "rd8b"};
        vecs[6]  = '{1'b0, 1'b1, 32'h104, 32'hAAAA,     32'h1234,     "wr104"};
        vecs[7]  = '{1'b1, 1'b0, 32'h4,   32'h0,        32'hAAAA,     "rd4wrap"};
        vecs[8]  = '{1'b1, 1'b0, 32'h7,   32'h0,        32'hAAAA,     "rd7low"};
        vecs[9]  = '{1'b0, 1'b1, 32'h20,  32'h1111,     32'hAAAA,     "wr20"};
        vecs[10] = '{1'b1, 1'b0, 32'h20,  32'h0,        32'h1111,     "rd20"};
        vecs[11] = '{1'b0, 1'b1, 32'hFC,  32'hCAFE0001, 32'h1111,     "wrFC"};
        vecs[12] = '{1'b0, 1'b1, 32'hF8,  32'h2,        32'h1111,     "wrF8"};
        vecs[13] = '{1'b1, 1'b0, 32'hFC,  32'h0,        32'hCAFE0001, "rdFC"};

        rst = 1'b1;
        ren = 1'b0; wen = 1'b0; addr = 32'd0; wdata = 32'd0;
        ren1 = 1'b0; wen1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset busy1", {31'd0, busy1}, 32'd0);
        check("reset rdata1", rdata1, 32'd0);
`ifdef MEM_RESPONDER_DISPLAY_EN
        check("reset display", display, 32'd0);
`endif

        foreach (vecs[i]) begin
            txn(vecs[i]);
`ifdef MEM_RESPONDER_DISPLAY_EN
            if (i == 11) check("display after wrFC", display, 32'hCAFE0001);
            if (i == 12) check("display after wrF8", display, 32'hCAFE0001);
`endif
        end

        // Reset during WAIT aborts the write and clears rdata.
        @(posedge clk); #1;
        wen = 1'b1; addr = 32'h20; wdata = 32'h9999;
        @(negedge clk);
        check("abort busy T", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wen = 1'b0;
        @(negedge clk);
        check("abort busy after rst", {31'd0, busy}, 32'd0);
        check("abort rdata after rst", rdata, 32'd0);
        txn('{1'b1, 1'b0, 32'h20, 32'h0, 32'h1111, "rd20 after abort"});

        // LATENCY=1: seed word 1 with 0x5, then hold a read.
        @(posedge clk); #1;
        wen1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h5;
        @(negedge clk);
        check("l1 wr busy T", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        check("l1 wr busy DONE", {31'd0, busy1}, 32'd0);
        check("l1 wr rdata", rdata1, 32'd0);
        wen1 = 1'b0;
        @(posedge clk); #1;
        ren1 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("l1 held busy c%0d", c), {31'd0, busy1}, (c % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("l1 held rdata c%0d", c), rdata1, (c == 0) ? 32'd0 : 32'd5);
        end
        ren1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

endmodule
